// File: rtl/qrr_arb_pkg.sv
// qrr_arb_pkg: shared state type and round-robin pointer helper for qrr_arb.
package qrr_arb_pkg;
  typedef enum logic {IDLE, LOCKED} arb_state_e;
  function automatic int rr_next(input int ptr, input int n);
    return (ptr + 1 >= n) ? 0 : ptr + 1;
  endfunction
endpackage

// File: rtl/qrr_arb_rr_prio_enc.sv
// rr_prio_enc: combinational round-robin priority encoder, searching from ptr upward modulo N.
module rr_prio_enc
  import qrr_arb_pkg::*;
#(
  parameter int N     = 2,
  parameter int W_SEL = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [W_SEL-1:0] ptr,
  output logic [W_SEL-1:0] gnt_idx,
  output logic             any
);
  logic [W_SEL:0]   sum [N];
  logic [W_SEL-1:0] idx [N];
  for (genvar k = 0; k < N; k++) begin : g_idx
    assign sum[k] = {1'b0, ptr} + (W_SEL+1)'(k);
    assign idx[k] = (sum[k] >= (W_SEL+1)'(N)) ? W_SEL'(sum[k] - (W_SEL+1)'(N)) : sum[k][W_SEL-1:0];
  end
  // Scan from the farthest candidate down so the one nearest ptr wins.
  always_comb begin
    gnt_idx = '0;
    for (int k = N - 1; k >= 0; k--)
      if (req[idx[k]]) gnt_idx = idx[k];
  end
  assign any = |req;
endmodule

// File: rtl/qrr_arb.sv
// qrr_arb: round-robin arbiter sharing one queue channel, locking the grant until a transaction ends.
module qrr_arb
  import qrr_arb_pkg::*;
#(
  parameter int W_DATA  = 16,
  parameter int LVL     = 1,
  parameter int N       = 2,
  parameter int W_SEL   = (N > 1) ? $clog2(N) : 1,
  parameter int ARB_LVL = LVL
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [N-1:0]                  din_valid,
  input  logic [N-1:0][LVL+W_DATA-1:0]  din_data,
  output logic [N-1:0]                  din_ready,
  output logic                          dout_valid,
  output logic [LVL+W_SEL+W_DATA-1:0]   dout_data,
  input  logic                          dout_ready
);
  arb_state_e           state;
  logic [W_SEL-1:0]     owner, rr_ptr, enc_idx, g;
  logic [LVL+W_DATA-1:0] sel;
  logic                 any, last, hs;
  rr_prio_enc #(.N(N), .W_SEL(W_SEL)) u_enc (
    .req     (din_valid),
    .ptr     (rr_ptr),
    .gnt_idx (enc_idx),
    .any     (any)
  );
  assign g   = (state == LOCKED) ? owner : enc_idx;
  assign sel = din_data[g];
  if (ARB_LVL == 0) begin : g_last_any
    assign last = 1'b1;
  end else begin : g_last_eot
    assign last = &sel[W_DATA +: ARB_LVL];
  end
  // Outputs are forced quiet while reset is held, independent of the inputs.
  assign dout_valid = rst & ((state == LOCKED) ? din_valid[owner] : any);
  assign dout_data  = {sel[W_DATA +: LVL], g, sel[W_DATA-1:0]};
  assign din_ready  = rst ? (N'(dout_ready) << g) : '0;
  assign hs         = dout_valid & dout_ready;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      owner  <= '0;
      rr_ptr <= '0;
    end else if (hs && last) begin
      state  <= IDLE;
      rr_ptr <= W_SEL'(rr_next(int'(g), N));
    end else if (dout_valid && state == IDLE) begin
      state <= LOCKED;
      owner <= g;
    end
  end
endmodule

// File: tb/tb_qrr_arb.sv
// tb_qrr_arb: directed checks of qrr_arb locking, fairness, stall stability, eot levels and reset.
module tb_qrr_arb;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  int n_chk = 0;
  int n_fail = 0;
  logic [1:0]        a_vld = '0, a_rdy;
  logic [1:0][16:0]  a_dat = '0;
  logic              a_ov, a_ordy = 1'b0;
  logic [17:0]       a_od;
  logic [3:0]        b_vld = '0, b_rdy;
  logic [3:0][17:0]  b_dat = '0;
  logic              b_ov, b_ordy = 1'b0;
  logic [19:0]       b_od;
  logic [1:0]        c_vld = '0, c_rdy;
  logic [1:0][17:0]  c_dat = '0;
  logic              c_ov, c_ordy = 1'b0;
  logic [18:0]       c_od;
  logic [1:0]  arb_eot [5] = '{2'b01, 2'b10, 2'b10, 2'b11, 2'b01};
  logic [15:0] arb_d0  [5] = '{16'hA000, 16'hA001, 16'hA001, 16'hA002, 16'hA003};
  logic [19:0] arb_exp [5] = '{20'h4A000, 20'h5B000, 20'h8A001, 20'hCA002, 20'h5B000};
  qrr_arb #(.W_DATA(16), .LVL(1), .N(2)) u_a (
    .clk(clk), .rst(rst), .din_valid(a_vld), .din_data(a_dat), .din_ready(a_rdy),
    .dout_valid(a_ov), .dout_data(a_od), .dout_ready(a_ordy));
  qrr_arb #(.W_DATA(16), .LVL(2), .N(4), .ARB_LVL(1)) u_b (
    .clk(clk), .rst(rst), .din_valid(b_vld), .din_data(b_dat), .din_ready(b_rdy),
    .dout_valid(b_ov), .dout_data(b_od), .dout_ready(b_ordy));
  qrr_arb #(.W_DATA(16), .LVL(2), .N(2), .ARB_LVL(0)) u_c (
    .clk(clk), .rst(rst), .din_valid(c_vld), .din_data(c_dat), .din_ready(c_rdy),
    .dout_valid(c_ov), .dout_data(c_od), .dout_ready(c_ordy));
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    a_vld = '0;
    b_vld = '0;
    c_vld = '0;
    @(negedge clk);
    rst = 1'b1;
  endtask
  initial begin
    @(negedge clk);
    @(negedge clk);
    a_vld = 2'b01;
    a_ordy = 1'b1;
    a_dat[0] = {1'b1, 16'h0011};
    #1;
    chk("rst_valid", a_ov, 1'b0);
    chk("rst_ready", a_rdy, 2'b00);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("first_valid", a_ov, 1'b1);
    chk("first_data", a_od, {1'b1, 1'b0, 16'h0011});
    chk("first_ready", a_rdy, 2'b01);
    do_reset();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      a_vld = 2'b11;
      a_dat[0] = {k == 2, 16'hA000 + 16'(k)};
      a_dat[1] = {1'b0, 16'hB000};
      #1;
      chk("lock_d0", a_od, {k == 2, 1'b0, 16'hA000 + 16'(k)});
      chk("lock_rdy0", a_rdy, 2'b01);
    end
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      a_vld = 2'b10;
      a_dat[1] = {k == 1, 16'hB000 + 16'(k)};
      #1;
      chk("lock_d1", a_od, {k == 1, 1'b1, 16'hB000 + 16'(k)});
      chk("lock_rdy1", a_rdy, 2'b10);
    end
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      a_ordy = (c == 5);
      a_vld = (c >= 2) ? 2'b11 : 2'b10;
      a_dat[0] = {1'b1, 16'hD000};
      a_dat[1] = {1'b1, 16'hC000};
      #1;
      chk("stall_valid", a_ov, 1'b1);
      chk("stall_data", a_od, {1'b1, 1'b1, 16'hC000});
      chk("stall_rdy", a_rdy, (c == 5) ? 2'b10 : 2'b00);
    end
    @(negedge clk);
    a_vld = 2'b11;
    #1;
    chk("after_stall", a_od, {1'b1, 1'b0, 16'hD000});
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      a_vld = 2'b10;
      a_dat[1] = {1'b0, 16'hE100 + 16'(k)};
      #1;
      chk("mid_beat", a_od, {1'b0, 1'b1, 16'hE100 + 16'(k)});
    end
    @(negedge clk);
    rst = 1'b0;
    a_vld = 2'b11;
    a_dat[0] = {1'b1, 16'hE000};
    #1;
    chk("mid_rst_valid", a_ov, 1'b0);
    chk("mid_rst_ready", a_rdy, 2'b00);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid_rst_regrant", a_od, {1'b1, 1'b0, 16'hE000});
    do_reset();
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      b_vld = 4'hF;
      b_ordy = 1'b1;
      for (int i = 0; i < 4; i++) b_dat[i] = {2'b01, 16'h1000 + 16'(i)};
      #1;
      chk("fair", b_od, {2'b01, 2'(c % 4), 16'h1000 + 16'(c % 4)});
    end
    do_reset();
    @(negedge clk);
    b_vld = 4'b0100;
    #1;
    chk("fair_one", b_od, {2'b01, 2'd2, 16'h1002});
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      b_vld = 4'hF;
      #1;
      chk("fair_ptr", b_od, {2'b01, 2'((c + 3) % 4), 16'h1000 + 16'((c + 3) % 4)});
    end
    do_reset();
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      b_vld = 4'b0011;
      b_dat[0] = {arb_eot[c], arb_d0[c]};
      b_dat[1] = {2'b01, 16'hB000};
      #1;
      chk("arb_lvl1", b_od, arb_exp[c]);
      if (c == 3) chk("arb_lvl1_rdy", b_rdy, 4'b0001);
    end
    do_reset();
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      c_vld = 2'b11;
      c_ordy = 1'b1;
      c_dat[0] = {2'b00, 16'hC000};
      c_dat[1] = {2'b00, 16'hC100};
      #1;
      chk("arb_lvl0", c_od, {2'b00, 1'(c % 2), (c % 2 == 1) ? 16'hC100 : 16'hC000});
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/qrr_arb.md
# qrr_arb

Round-robin arbiter that shares one downstream queue channel between N queue-typed DTI producers. Once a producer wins, it keeps the grant until its transaction ends, i.e. until the beat whose lowest ARB_LVL eot bits are all set. Each output beat carries the winning input index in a `ctrl` field, so downstream `qfilt` instances can demultiplex by SEL. The block sits in front of shared consumers in the svlib queue datapath.

## Interface
Parameters:
- W_DATA, 16, data field width per input beat
- LVL, 1, eot width of input and output queues
- N, 2, number of requesters (2..16)
- W_SEL, $clog2(N) (minimum 1), width of the `ctrl` index field
- ARB_LVL, LVL, eot levels that close a transaction (0..LVL); 0 re-arbitrates on every beat

Ports:
- Clocking: one clock; reset is asynchronous and active-low. Ports are `clk` and `rst`.
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous active-low reset
- din  dti.consumer [N-1:0]  LVL+W_DATA  requester streams, packed {eot[LVL-1:0], data[W_DATA-1:0]}
- dout  dti.producer  LVL+W_SEL+W_DATA  shared stream, packed {eot, ctrl[W_SEL-1:0], data}

## Operation
- Terms:
  - `last` = &din[g].eot[ARB_LVL-1:0]; forced to 1 when ARB_LVL=0.
  - `hs` = dout.valid && dout.ready.
- Registers:
  - state (IDLE/LOCKED)
  - owner [W_SEL]
  - rr_ptr [W_SEL]
- Reset values: state=IDLE, owner=0, rr_ptr=0.
- While rst is low: dout.valid=0 and all din.ready=0, regardless of inputs.
- Grant g:
  - IDLE: g = first index i with din[i].valid, searching rr_ptr, rr_ptr+1, … modulo N (wraps at N-1 to 0).
  - LOCKED: g = owner.
- Datapath (combinational):
  - dout.valid = din[g].valid; in IDLE with no valid input, dout.valid=0.
  - dout.data = {din[g].eot, g, din[g].data}.
  - din[g].ready = dout.ready; every other din.ready=0.
- IDLE transitions:
  - dout.valid && !(hs && last) -> LOCKED, owner<=g. This covers a stalled first beat and a multi-beat transaction, and keeps the grant stable while valid is held.
  - hs && last -> stay IDLE, rr_ptr <= g+1 mod N.
- LOCKED transitions:
  - hs && last -> IDLE, rr_ptr <= owner+1 mod N.
  - Any other case -> hold. Owner valid dropping mid-transaction does not release the lock; dout.valid simply follows it.
- Simultaneous requests: rotate fairly. No requester waits more than N-1 transactions.
- Reset mid-transaction: immediate return to IDLE with pointers zeroed; the partial transaction is abandoned.

## Timing
- Zero-cycle latency: combinational valid→valid, data→data and ready→ready paths. No registers on data.
- Back-to-back: the next transaction (other requester) may handshake in the cycle immediately after a `last` handshake. There is no bubble.
- ctrl is stable for every beat of a transaction.
- The grant never changes while dout.valid=1 without a handshake.

## Structure
- Package `qrr_arb_pkg`:
  - state enum {IDLE, LOCKED}
  - function `rr_next(ptr, N)` for modulo increment
- Sub-module `rr_prio_enc`:
  - combinational round-robin priority encoder
  - inputs: req[N], ptr[W_SEL]
  - outputs: gnt_idx[W_SEL], any
  - used for the IDLE grant
- Top level holds the state/owner/rr_ptr registers and the dti mux.

## Test plan
- Reset: rst=0 with din[0].valid=1 -> dout.valid=0, din[0].ready=0. After release, din[0] beat data=0x0011 with eot=1 passes same cycle with ctrl=0.
- Locking (N=2, LVL=1): din[0] sends a 3-beat transaction (eot 0,0,1) while din[1] is valid throughout -> dout shows 3 beats ctrl=0, then din[1] beats ctrl=1 with no idle cycle; din[1].ready=0 during the first 3 cycles.
- Fairness (N=4, all valid, single-beat transactions) -> ctrl sequence 0,1,2,3,0,1. After reset, with only din[2] valid, the first grant is 2 and rr_ptr becomes 3.
- Stall stability: din[1] valid, dout.ready=0 for 5 cycles, din[0] asserts valid at cycle 2 -> ctrl stays 1 and data unchanged until the handshake.
- ARB_LVL=1, LVL=2: eot sequence 01, 10, 11 from din[0] -> arbitration after each beat with eot[0]=1 (beats 1 and 3). With ARB_LVL=0 -> arbitration after every beat.
- Reset mid-transaction after beat 2 of 4 -> state IDLE, next grant computed from rr_ptr=0.
